// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline: per-stage hold/bubble, branch redirect, stall watchdog.
// Define PIPE_HAZARD_PERF_EN to add the stall-cycle / flush performance counters and their clear input.
module pipeline_hazard_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_stall_req,
  input  logic              ex_stall_req,
  input  logic              mem_stall_req,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [4:0]        hold,
  output logic [4:0]        bubble,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_target,
`ifdef PIPE_HAZARD_PERF_EN
  input  logic              perf_clr,
  output logic [CNT_W-1:0]  perf_stall_cyc,
  output logic [CNT_W-1:0]  perf_flush_cnt,
`endif
  output logic              stall_err
);

  typedef enum logic {RUN, PEND} state_t;

  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);

  state_t            state;
  logic [ADDR_W-1:0] saved_target;
  logic [CNT_W-1:0]  stall_cnt;
  logic              any_stall;
  logic              down_stall;
  logic              go_pend;

  assign any_stall  = id_stall_req | ex_stall_req | mem_stall_req;
  assign down_stall = ex_stall_req | mem_stall_req;

  always_comb begin
    hold        = '0;
    bubble      = '0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    go_pend     = 1'b0;
    if (!rst) begin
      if (mem_stall_req) begin
        hold   = 5'b01111;
        bubble = 5'b10000;
      end else if (ex_stall_req) begin
        hold   = 5'b00111;
        bubble = 5'b01000;
      end else if (id_stall_req) begin
        hold   = 5'b00011;
        bubble = 5'b00100;
      end

      if (state == PEND) begin
        // A held redirect overrides an ID stall: PC loads the target and IF/ID is squashed.
        if (!down_stall) begin
          pc_redirect = 1'b1;
          pc_target   = saved_target;
          hold[1:0]   = 2'b00;
          bubble[1]   = 1'b1;
        end
      end else if (branch_taken && !any_stall) begin
        pc_redirect = 1'b1;
        pc_target   = branch_target;
        bubble[1]   = 1'b1;
      end else if (branch_taken && down_stall) begin
        go_pend = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      saved_target <= '0;
      stall_cnt    <= '0;
      stall_err    <= 1'b0;
    end else begin
      case (state)
        RUN: if (go_pend) begin
          state        <= PEND;
          saved_target <= branch_target;
        end
        PEND: if (!down_stall) state <= RUN;
        default: state <= RUN;
      endcase

      if (any_stall) begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        if (stall_cnt >= TO_M1) stall_err <= 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (any_stall && perf_stall_cyc != '1) perf_stall_cyc <= perf_stall_cyc + 1'b1;
      if (pc_redirect && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl against a queue-based reference model of the stall/redirect rules.
module tb_pipeline_hazard_ctrl;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id, ex, mem, br;
  logic [AW-1:0] tgt;
  logic [4:0]    hold, bubble;
  logic          redir;
  logic [AW-1:0] ptgt;
  logic          err;
`ifdef PIPE_HAZARD_PERF_EN
  logic          perf_clr = 1'b0;
  logic [15:0]   perf_stall_cyc, perf_flush_cnt;
`endif

  pipeline_hazard_ctrl #(.ADDR_W(AW), .TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_stall_req(id), .ex_stall_req(ex), .mem_stall_req(mem),
    .branch_taken(br), .branch_target(tgt),
    .hold(hold), .bubble(bubble), .pc_redirect(redir), .pc_target(ptgt),
`ifdef PIPE_HAZARD_PERF_EN
    .perf_clr(perf_clr), .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt),
`endif
    .stall_err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding redirect targets, length of the current stall run, sticky error.
  logic [AW-1:0] pend_q[$];
  int            run_len = 0;
  bit            m_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit i, input bit e, input bit m, input bit b, input logic [AW-1:0] t);
    int            lvl;
    logic [4:0]    eh, eb;
    bit            er;
    logic [AW-1:0] et;
    @(negedge clk);
    rst = 1'b0; id = i; ex = e; mem = m; br = b; tgt = t;
    #1;
    lvl = m ? 4 : e ? 3 : i ? 2 : 0;
    eh  = 5'((1 << lvl) - 1);
    eb  = (lvl != 0) ? 5'(1 << lvl) : 5'd0;
    er  = 1'b0;
    et  = '0;
    if (pend_q.size() > 0) begin
      if (!e && !m) begin
        er = 1'b1;
        et = pend_q.pop_front();
        eh = eh & 5'b11100;
        eb = eb | 5'b00010;
      end
    end else if (b) begin
      if (lvl == 0) begin
        er = 1'b1;
        et = t;
        eb = eb | 5'b00010;
      end else if (lvl >= 3) begin
        pend_q.push_back(t);
      end
    end
    check("hold", hold, eh);
    check("bubble", bubble, eb);
    check("redirect", redir, er);
    check("target", ptgt, et);
    check("stall_err", err, m_err);
    if (i || e || m) begin
      run_len++;
      if (run_len >= TO) m_err = 1'b1;
    end else begin
      run_len = 0;
    end
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    rst = 1'b1;
    id = 1'($urandom); ex = 1'($urandom); mem = 1'($urandom); br = 1'($urandom); tgt = $urandom;
    #1;
    check("rst_hold", hold, 0);
    check("rst_bubble", bubble, 0);
    check("rst_redirect", redir, 0);
    check("rst_target", ptgt, 0);
    pend_q.delete();
    run_len = 0;
    m_err   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; id = 0; ex = 0; mem = 0; br = 0; tgt = '0;
    reset_cycle();
    reset_cycle();
    step(0, 0, 0, 0, 0);

    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 32'h40);

    step(0, 0, 1, 1, 32'h80);
    step(0, 0, 1, 1, 32'h11);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    step(0, 1, 0, 1, 32'h99);
    step(1, 0, 0, 1, 32'h55);
    step(1, 0, 0, 1, 32'h77);

    reset_cycle();
    for (int k = 0; k < 6; k++) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    reset_cycle();
    step(0, 0, 0, 0, 0);

    step(0, 1, 0, 1, 32'hAB);
    reset_cycle();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_cycle();
      end else begin
        step($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 15,
             $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 30, $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
